// File: rtl/servo_setpoint_encoder_pkg.sv
// Shared constants for the servo tester front end: setpoint range, default
// centre value and the quadrature phase encoding.
package servo_pkg;

    localparam int SETPOINT_W     = 8;
    localparam int SETPOINT_MAX   = 255;
    localparam int CENTER_DEFAULT = 128;

    // Detent rests at AB=11; clockwise walks 11 -> 10 -> 00 -> 01 -> 11.
    localparam logic [1:0] QUAD_S0 = 2'b11;
    localparam logic [1:0] QUAD_S1 = 2'b10;
    localparam logic [1:0] QUAD_S2 = 2'b00;
    localparam logic [1:0] QUAD_S3 = 2'b01;

    // Position of an AB pair along the clockwise cycle (0..3).
    function automatic logic [1:0] quad_phase(input logic [1:0] ab);
        case (ab)
            QUAD_S0: return 2'd0;
            QUAD_S1: return 2'd1;
            QUAD_S2: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/servo_setpoint_encoder_if.sv
// Pin and setpoint bundle between the encoder pins, the encoder front end
// and the PWM stage.
interface servo_setpoint_encoder_if;

    logic                              enc_a;
    logic                              enc_b;
    logic                              enc_btn;
    logic                              fast;
    logic [servo_pkg::SETPOINT_W-1:0]  setpoint;
    logic                              setpoint_valid;
    logic                              enc_err;

    modport master (
        output enc_a, enc_b, enc_btn, fast,
        input  setpoint, setpoint_valid, enc_err
    );

    modport slave (
        input  enc_a, enc_b, enc_btn, fast,
        output setpoint, setpoint_valid, enc_err
    );

endinterface

// File: rtl/servo_setpoint_encoder_debounce.sv
// Two-flop synchronizer followed by a stable-count filter: the output only
// follows the pin after DEBOUNCE_CYCLES consecutive differing samples.
module servo_debounce #(
    parameter int   DEBOUNCE_CYCLES = 10000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            deb_q   <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/servo_setpoint_encoder.sv
// Rotary encoder front end: debounced quadrature decode into saturating
// setpoint steps, with the push button recalling the centre position.
module servo_setpoint_encoder
    import servo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int STEP            = 1,
    parameter int FAST_STEP       = 8,
    parameter int CENTER          = CENTER_DEFAULT
) (
    input logic                     clk,
    input logic                     rst_n,
    servo_setpoint_encoder_if.slave bus
);

    logic a_deb, b_deb, btn_deb;
    logic fast_s1_q, fast_s2_q;

    servo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_deb_a (
        .clk(clk), .rst_n(rst_n), .din(bus.enc_a), .dout(a_deb)
    );
    servo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_deb_b (
        .clk(clk), .rst_n(rst_n), .din(bus.enc_b), .dout(b_deb)
    );
    servo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_deb_btn (
        .clk(clk), .rst_n(rst_n), .din(bus.enc_btn), .dout(btn_deb)
    );

    logic [1:0]            ab_prev_q;
    logic                  btn_prev_q;
    logic signed [2:0]     q_q, q_d;
    logic                  inc_q, inc_d, dec_q, dec_d;
    logic                  btn_rise_q, btn_rise_d;
    logic                  err_q, err_d;
    logic [SETPOINT_W-1:0] setpoint_q, setpoint_d;
    logic                  valid_q, valid_d;
    logic [1:0]            ab_cur, delta;
    logic [SETPOINT_W:0]   step9, sum9, diff9;

    // Phase difference mod 4: 1 = CW quarter, 3 = CCW quarter, 2 = both bits flipped.
    always_comb begin
        ab_cur     = {a_deb, b_deb};
        delta      = quad_phase(ab_cur) - quad_phase(ab_prev_q);
        q_d        = q_q;
        inc_d      = 1'b0;
        dec_d      = 1'b0;
        err_d      = 1'b0;
        btn_rise_d = btn_deb & ~btn_prev_q;
        case (delta)
            2'd1: begin
                if (q_q == 3'sd3) begin
                    inc_d = 1'b1;
                    q_d   = '0;
                end else begin
                    q_d = q_q + 3'sd1;
                end
            end
            2'd3: begin
                if (q_q == -3'sd3) begin
                    dec_d = 1'b1;
                    q_d   = '0;
                end else begin
                    q_d = q_q - 3'sd1;
                end
            end
            2'd2:    err_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        step9      = fast_s2_q ? (SETPOINT_W+1)'(FAST_STEP) : (SETPOINT_W+1)'(STEP);
        sum9       = {1'b0, setpoint_q} + step9;
        diff9      = {1'b0, setpoint_q} - step9;
        setpoint_d = setpoint_q;
        if (btn_rise_q) begin
            setpoint_d = SETPOINT_W'(CENTER);
        end else if (inc_q) begin
            setpoint_d = (sum9 > (SETPOINT_W+1)'(SETPOINT_MAX)) ? SETPOINT_W'(SETPOINT_MAX)
                                                               : sum9[SETPOINT_W-1:0];
        end else if (dec_q) begin
            setpoint_d = diff9[SETPOINT_W] ? '0 : diff9[SETPOINT_W-1:0];
        end
        valid_d = (setpoint_d != setpoint_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fast_s1_q  <= 1'b0;
            fast_s2_q  <= 1'b0;
            ab_prev_q  <= QUAD_S0;
            btn_prev_q <= 1'b0;
            q_q        <= '0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            btn_rise_q <= 1'b0;
            err_q      <= 1'b0;
            setpoint_q <= SETPOINT_W'(CENTER);
            valid_q    <= 1'b0;
        end else begin
            fast_s1_q  <= bus.fast;
            fast_s2_q  <= fast_s1_q;
            ab_prev_q  <= ab_cur;
            btn_prev_q <= btn_deb;
            q_q        <= q_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            btn_rise_q <= btn_rise_d;
            err_q      <= err_d;
            setpoint_q <= setpoint_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.setpoint       = setpoint_q;
    assign bus.setpoint_valid = valid_q;
    assign bus.enc_err        = err_q;

endmodule

// File: tb/tb_servo_setpoint_encoder.sv
// Scenario bench for servo_setpoint_encoder with a detent-level setpoint model.
module tb_servo_setpoint_encoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    servo_setpoint_encoder_if bus();

    servo_setpoint_encoder #(
        .DEBOUNCE_CYCLES(4),
        .STEP(1),
        .FAST_STEP(8),
        .CENTER(128)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int vcnt  = 0;
    int ecnt  = 0;
    int model_sp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.setpoint_valid) vcnt++;
            if (bus.enc_err) ecnt++;
        end
    end

    task automatic quarter(input logic [1:0] ab, input int hold);
        @(posedge clk); #1;
        bus.enc_a = ab[1];
        bus.enc_b = ab[0];
        repeat (hold) @(posedge clk);
    endtask

    task automatic detent(input bit cw, input int hold);
        if (cw) begin
            quarter(2'b10, hold); quarter(2'b00, hold); quarter(2'b01, hold); quarter(2'b11, hold);
        end else begin
            quarter(2'b01, hold); quarter(2'b00, hold); quarter(2'b10, hold); quarter(2'b11, hold);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.enc_a = 1'b1; bus.enc_b = 1'b1; bus.enc_btn = 1'b0; bus.fast = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_sp = 128;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.setpoint !== 8'd128 || bus.setpoint_valid !== 1'b0 || bus.enc_err !== 1'b0) begin
                n_bad++;
                $display("FAIL reset cyc%0d: sp=%0d valid=%b err=%b, expected sp=128 valid=0 err=0",
                         i, bus.setpoint, bus.setpoint_valid, bus.enc_err);
            end
        end
    endtask

    task automatic test_cw_detent();
        int v0 = vcnt;
        quarter(2'b10, 10); quarter(2'b00, 10); quarter(2'b01, 10);
        @(posedge clk); #1;
        bus.enc_a = 1'b1; bus.enc_b = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.setpoint !== 8'd128) begin
            n_bad++; $display("FAIL cw_early: sp=%0d expected 128 at edge 7", bus.setpoint);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.setpoint !== 8'd129 || bus.setpoint_valid !== 1'b1) begin
            n_bad++; $display("FAIL cw_edge8: sp=%0d valid=%b expected 129/1", bus.setpoint, bus.setpoint_valid);
        end
        repeat (5) @(posedge clk); #1;
        model_sp = 129;
        n_cmp++;
        if (vcnt - v0 !== 1) begin
            n_bad++; $display("FAIL cw_pulses: got %0d expected 1", vcnt - v0);
        end
    endtask

    task automatic test_glitch();
        int v0 = vcnt;
        int e0 = ecnt;
        @(posedge clk); #1 bus.enc_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.enc_a = 1'b1;
        repeat (20) @(posedge clk); #1;
        n_cmp++;
        if (bus.setpoint !== 8'(model_sp) || vcnt != v0 || ecnt != e0) begin
            n_bad++;
            $display("FAIL glitch: sp=%0d valid_pulses=%0d err_pulses=%0d expected sp=%0d 0 0",
                     bus.setpoint, vcnt - v0, ecnt - e0, model_sp);
        end
    endtask

    task automatic test_illegal();
        int v0 = vcnt;
        int e0 = ecnt;
        quarter(2'b00, 15); #1;
        n_cmp++;
        if (ecnt - e0 !== 1 || bus.setpoint !== 8'(model_sp)) begin
            n_bad++; $display("FAIL illegal_11_00: err_pulses=%0d sp=%0d expected 1 %0d", ecnt - e0, bus.setpoint, model_sp);
        end
        quarter(2'b11, 15); #1;
        n_cmp++;
        if (ecnt - e0 !== 2 || vcnt != v0 || bus.setpoint !== 8'(model_sp)) begin
            n_bad++; $display("FAIL illegal_00_11: err_pulses=%0d valid_pulses=%0d sp=%0d expected 2 0 %0d",
                              ecnt - e0, vcnt - v0, bus.setpoint, model_sp);
        end
    endtask

    task automatic check_detent(input bit cw, input bit fst, input int hold, input string tag);
        int v0 = vcnt;
        int step = fst ? 8 : 1;
        int nxt = cw ? model_sp + step : model_sp - step;
        if (nxt > 255) nxt = 255;
        if (nxt < 0) nxt = 0;
        detent(cw, hold);
        n_cmp++;
        if (bus.setpoint !== 8'(nxt) || (vcnt - v0) != ((nxt != model_sp) ? 1 : 0)) begin
            n_bad++;
            $display("FAIL %s: sp=%0d pulses=%0d expected sp=%0d pulses=%0d",
                     tag, bus.setpoint, vcnt - v0, nxt, (nxt != model_sp) ? 1 : 0);
        end
        model_sp = nxt;
    endtask

    task automatic test_saturation();
        apply_reset();
        bus.fast = 1'b1;
        repeat (5) @(posedge clk);
        for (int i = 0; i < 20; i++) check_detent(1'b1, 1'b1, 10, "sat_up");
        bus.fast = 1'b0;
        repeat (5) @(posedge clk);
        for (int i = 0; i < 40; i++) check_detent(1'b0, 1'b0, 10, "sat_down");
        n_cmp++;
        if (bus.setpoint !== 8'd215) begin
            n_bad++; $display("FAIL sat_final: sp=%0d expected 215", bus.setpoint);
        end
    endtask

    task automatic test_button();
        int v0;
        for (int k = 0; k < 2; k++) begin
            v0 = vcnt;
            @(posedge clk); #1 bus.enc_btn = 1'b1;
            repeat (12) @(posedge clk);
            #1 bus.enc_btn = 1'b0;
            repeat (12) @(posedge clk); #1;
            n_cmp++;
            if (bus.setpoint !== 8'd128 || (vcnt - v0) != ((k == 0) ? 1 : 0)) begin
                n_bad++; $display("FAIL button%0d: sp=%0d pulses=%0d expected 128 %0d",
                                  k, bus.setpoint, vcnt - v0, (k == 0) ? 1 : 0);
            end
        end
        model_sp = 128;
    endtask

    task automatic test_button_with_inc();
        int v0;
        check_detent(1'b1, 1'b0, 10, "pre_coincide");
        quarter(2'b10, 10); quarter(2'b00, 10); quarter(2'b01, 10);
        v0 = vcnt;
        @(posedge clk); #1;
        bus.enc_a = 1'b1; bus.enc_b = 1'b1; bus.enc_btn = 1'b1;
        repeat (15) @(posedge clk); #1;
        n_cmp++;
        if (bus.setpoint !== 8'd128 || vcnt - v0 !== 1) begin
            n_bad++; $display("FAIL btn_inc: sp=%0d pulses=%0d expected 128 1", bus.setpoint, vcnt - v0);
        end
        bus.enc_btn = 1'b0;
        repeat (15) @(posedge clk); #1;
        model_sp = 128;
        n_cmp++;
        if (bus.setpoint !== 8'd128) begin
            n_bad++; $display("FAIL btn_release: sp=%0d expected 128", bus.setpoint);
        end
    endtask

    task automatic test_random();
        bit cw, fst;
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            cw  = 1'($urandom_range(0, 1));
            fst = 1'($urandom_range(0, 1));
            bus.fast = fst;
            repeat (4) @(posedge clk);
            check_detent(cw, fst, int'($urandom_range(6, 12)), "random");
        end
        bus.fast = 1'b0;
    endtask

    task automatic test_mid_reset();
        int v0, e0;
        check_detent(1'b1, 1'b0, 10, "pre_midreset");
        quarter(2'b10, 10); quarter(2'b00, 10);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.setpoint !== 8'd128) begin
            n_bad++; $display("FAIL async_reset: sp=%0d expected 128 before next edge", bus.setpoint);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_sp = 128;
        v0 = vcnt; e0 = ecnt;
        repeat (15) @(posedge clk); #1;
        n_cmp++;
        if (ecnt - e0 !== 1) begin
            n_bad++; $display("FAIL midreset_err: err_pulses=%0d expected 1", ecnt - e0);
        end
        quarter(2'b01, 10); quarter(2'b11, 10);
        repeat (10) @(posedge clk); #1;
        n_cmp++;
        if (bus.setpoint !== 8'd128 || vcnt != v0) begin
            n_bad++; $display("FAIL midreset_step: sp=%0d pulses=%0d expected 128 0", bus.setpoint, vcnt - v0);
        end
    endtask

    initial begin
        test_reset();
        test_cw_detent();
        test_glitch();
        test_illegal();
        test_saturation();
        test_button();
        test_button_with_inc();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/servo_setpoint_encoder.md
# servo_setpoint_encoder

Front-end stage of the servo tester. It turns a hand-operated quadrature rotary encoder with a push button into the 8-bit position setpoint that the PWM/ramp stage consumes on `ui_in`. Every input is synchronized and debounced. Detents are decoded into saturating up/down steps, and the button recentres the servo. `setpoint` drives the PWM stage directly; `setpoint_valid` marks each change.

## Interface
- `DEBOUNCE_CYCLES`, default 10000: consecutive stable cycles required before a debounced input changes (1 ms at 10 MHz); must be ≥ 1.
- `STEP`, default 1: setpoint change per detent with `fast` low.
- `FAST_STEP`, default 8: setpoint change per detent with `fast` high.
- `CENTER`, default 128: reset and button-recall value of `setpoint`.

- `clk`, input, 1: single clock for the whole block.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `enc_a`, input, 1: encoder channel A, raw pin.
- `enc_b`, input, 1: encoder channel B, raw pin.
- `enc_btn`, input, 1: push button, active-high, raw pin.
- `fast`, input, 1: coarse-step select, raw pin; synchronized only, not debounced.
- `setpoint`, output, 8: current setpoint, unsigned 0..255.
- `setpoint_valid`, output, 1: one-cycle pulse in the cycle `setpoint` takes a new value.
- `enc_err`, output, 1: one-cycle pulse on an illegal quadrature transition.

## Operation
- **Synchronizers:** every raw input passes through a 2-flop synchronizer.
  - Reset values: `enc_a` and `enc_b` flops reset to 1 (detent rests at AB=11); `enc_btn` and `fast` flops reset to 0.
- **Debouncer** (on A, B and button):
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - When sync equals deb, the counter clears to 0.
  - Otherwise the counter increments. When it would reach `DEBOUNCE_CYCLES`, deb takes the sync value and the counter clears.
  - Reset: deb A = 1, deb B = 1, deb btn = 0, counters = 0.
- **Quadrature decoder:**
  - Compares registered previous {A,B} with current debounced {A,B}.
  - CW sequence is 11→10→00→01→11; CCW is the reverse.
  - A quarter accumulator `q` (signed, range −3..+3, reset 0) takes +1 on each CW quarter and −1 on each CCW quarter.
  - If a step would make `q` equal +4, emit `inc` and clear `q` to 0. If it would make `q` equal −4, emit `dec` and clear `q` to 0.
  - If both bits change in the same cycle: pulse `enc_err` and leave `q` unchanged. The new state becomes the reference.
- **Setpoint register:**
  - Reset value is `CENTER`.
  - Button edge (debounced 0→1): `setpoint` ← `CENTER`. This has priority over `inc`/`dec` in the same cycle.
  - `inc`: `setpoint` ← min(255, `setpoint` + step). `dec`: `setpoint` ← max(0, `setpoint` − step).
  - step is `FAST_STEP` if synchronized `fast` = 1 in that cycle, else `STEP`.
  - Arithmetic uses a 9-bit intermediate for the saturation check.
- **`setpoint_valid`:** pulses only if the new value differs from the old. It stays 0 on:
  - saturated steps at 0 or 255;
  - a button press while `setpoint` already equals `CENTER`.
- **Mid-operation reset:** deasserting `rst_n` mid-rotation discards `q`, all debounce counters and `setpoint` immediately (asynchronous).
- **Pins at 00 after reset:** debounced AB goes 11→00. This is an illegal transition: it produces `enc_err` and no step.

## Timing
- Reset values: `setpoint` = `CENTER`, `setpoint_valid` = 0, `enc_err` = 0.
- Latency, pin change to debounced change: the debounced value changes on clock edge 2 + `DEBOUNCE_CYCLES` after the raw pin change. The pin must be held stable throughout.
- Latency, detent-completing pin change to output: `setpoint` and `setpoint_valid` update on edge `DEBOUNCE_CYCLES` + 4.
- Latency, illegal transition to `enc_err`: `enc_err` pulses on edge `DEBOUNCE_CYCLES` + 3.
- Glitch rejection: a pin glitch shorter than `DEBOUNCE_CYCLES` cycles (after sync) produces no change.
- Event rate: at most one `inc`/`dec` per cycle; at most one setpoint update per cycle.
- Outputs are registered; there are no combinational paths from inputs.

## Structure
- Shared package `servo_pkg`:
  - `SETPOINT_W` = 8, `SETPOINT_MAX` = 255;
  - default `CENTER`;
  - quadrature state encoding constants (11/10/00/01).
- Sub-module `servo_debounce`: 2-flop synchronizer plus stable-count filter, parameterized by `DEBOUNCE_CYCLES` and reset value. It is instantiated three times (A, B, button).
- The top level holds the decoder, the `q` accumulator and the setpoint register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- **Reset:** release `rst_n` with pins AB=11, btn=0 → `setpoint` = 128, `setpoint_valid` = 0, `enc_err` = 0 for 50 cycles.
- **One CW detent:** drive one CW detent, each phase held 10 cycles → `setpoint` 128→129 exactly 8 edges after the final 01→11 pin change, one `setpoint_valid` pulse.
- **Glitch and illegal transition:**
  - 3-cycle glitch on `enc_a` → no change, no pulse.
  - AB 11→00 held → one `enc_err` pulse, `setpoint` unchanged.
- **Saturation:**
  - With `fast` = 1, 20 CW detents from 128 → 136…248, then 255; further CW detents give no `setpoint_valid`.
  - 40 CCW detents with `fast` = 0 from 255 → 215.
- **Button:**
  - Button press at `setpoint` = 215 → 128 with one pulse.
  - Second press → no pulse.
  - Button edge coinciding with a detent `inc` → 128.
- **Reset mid-rotation:** assert `rst_n` low after 2 CW quarters, release, complete the rotation → `q` restarted at 0, `setpoint` = 128, no step from the partial detent.
